pipe_seq_ctl: RTL and testbench
===============================

# pipe_seq_ctl

Pipeline sequencing controller for the 4-stage CPU. It sits beside the fetch/decode/execute/memory stage registers and decides, every cycle, whether each stage advances, holds or is flushed, and what the PC loads next. It absorbs load-use detection, taken-branch redirect, multi-cycle data-memory waits and halt into one state machine. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- PC_W, 8, program counter width
- REG_W, 4, register index width
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before error
- CNT_W, 16, stall counter width
---
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  PC_W  current fetch PC
- ld_ex  in  1  instruction in EX is a load (MemRd)
- ld_dest  in  REG_W  destination of that load
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_W  ID source registers
- br_taken  in  1  EX resolves a taken branch
- br_target  in  PC_W  branch target
- mem_req  in  1  MEM stage access in progress
- mem_ack  in  1  data memory completes access this cycle
- halt_req  in  1  halt instruction in MEM stage
- pc_we  out  1  PC register load enable
- pc_next  out  PC_W  value PC loads when pc_we=1
- ifid_we, idex_we, exmem_we  out  1  stage register enables
- ifid_flush, idex_flush  out  1  insert bubble into that stage register
- halted  out  1  core stopped
- mem_err  out  1  sticky memory timeout
- stall_cnt  out  CNT_W  stalled-cycle count

## Operation
- States: RUN, LU_STALL, MEM_WAIT, HALT. State and counters are registered. Stage controls are combinational from state and inputs.
- Load-use hazard (lu):
  - Condition: ld_ex && id_valid && ld_dest!=0 && (ld_dest==id_src1 || ld_dest==id_src2).
  - Register 0 never causes a hazard.
- Priority in RUN, highest first:
  1. mem_req && !mem_ack: all we=0, no flush. Load wait counter with MEM_TIMEOUT. Go to MEM_WAIT.
  2. halt_req: pc_we=ifid_we=idex_we=0, exmem_we=1, idex_flush=1. Go to HALT.
  3. br_taken: pc_we=1, pc_next=br_target, ifid_flush=idex_flush=1, all we=1. Stay in RUN.
  4. lu: pc_we=ifid_we=0, idex_flush=1, exmem_we=1. Go to LU_STALL.
  5. Otherwise: all we=1, pc_next=pc+1 modulo 2^PC_W (0xFF→0x00). No flush.
- LU_STALL lasts exactly one cycle:
  - lu detection is suppressed in this state.
  - Items 1–3 are still evaluated.
  - Otherwise behaves as normal advance.
  - Returns to RUN, or goes to MEM_WAIT/HALT per the rule taken.
- MEM_WAIT:
  - All we=0, no flush.
  - Wait counter decrements each cycle.
  - mem_ack: normal advance in that same cycle, go to RUN. br_taken and lu are evaluated as in RUN.
  - Counter reaches 0 with no ack: set mem_err, go to HALT.
  - mem_ack on the final counted cycle wins over the timeout.
- HALT:
  - pc_we and all stage we=0; halted=1.
  - Left only by rst.
- stall_cnt:
  - Increments in every non-reset cycle with pc_we=0, except in HALT.
  - Saturates at all-ones.
- Reset values (asserted asynchronously; held while rst=1):
  - state=RUN; pc_next=0.
  - pc_we, ifid_we, idex_we, exmem_we = 0.
  - ifid_flush, idex_flush = 1.
  - halted=0, mem_err=0, stall_cnt=0.

## Timing
- Zero-cycle latency: controls respond to inputs in the same cycle. No input-to-output path passes through the stage registers.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 flushed slots and 0 stall cycles.
- MEM_WAIT lasts N cycles for an ack arriving N cycles after entry, N ≤ MEM_TIMEOUT.
- Reset mid-MEM_WAIT or mid-HALT:
  - Immediately returns to RUN values.
  - Clears the wait counter, mem_err and stall_cnt.

## Structure
- Shared package: state enum and PC_W/REG_W constants, reused by the existing hazard logic and stage registers.
- One sub-module, lu_detect: combinational load-use compare that produces lu.
- Wait timer and stall counter stay inline.

## Test plan
- Load-use: ld_ex=1, ld_dest=3, id_src2=3, pc=0x10 → one cycle with pc_we=0, idex_flush=1, stall_cnt=1; next cycle pc_next=0x11.
- Register 0: ld_dest=0=id_src1 → no stall, pc_next=pc+1.
- Branch and hazard together: br_taken=1, br_target=0x40, lu true → pc_next=0x40, both flushes, no stall, state stays RUN.
- Memory wait: mem_req held, mem_ack after 4 cycles → 4 frozen cycles, stall_cnt=4, advance on the ack cycle. Separately, no ack for 15 cycles → mem_err=1, halted=1.
- Wrap: pc=0xFF with normal advance → pc_next=0x00.
- Reset asserted mid-MEM_WAIT asynchronously → outputs take reset values before the next clock edge; normal run resumes after release.

Source files
------------

// File: rtl/pipe_seq_ctl_pkg.sv
// rtl/pipe_seq_ctl_pkg.sv - shared sequencer state encoding and default widths
package pipe_seq_ctl_pkg;

  localparam int DEF_PC_W        = 8;
  localparam int DEF_REG_W       = 4;
  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_STALL,
    ST_MEM_WAIT,
    ST_HALT
  } seq_state_t;

endpackage

// File: rtl/pipe_seq_ctl_lu_detect.sv
// rtl/pipe_seq_ctl_lu_detect.sv - load-use hazard compare between the EX load and the ID sources
module pipe_seq_ctl_lu_detect
  import pipe_seq_ctl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             ld_ex,
  input  logic [REG_W-1:0] ld_dest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  output logic             lu
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency
  assign lu = ld_ex && id_valid && (ld_dest != '0) &&
              ((ld_dest == id_src1) || (ld_dest == id_src2));

endmodule

// File: rtl/pipe_seq_ctl.sv
// rtl/pipe_seq_ctl.sv - pipeline advance/hold/flush sequencer with memory wait timer and stall counter
module pipe_seq_ctl
  import pipe_seq_ctl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc,
  input  logic             ld_ex,
  input  logic [REG_W-1:0] ld_dest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_req,
  output logic             pc_we,
  output logic [PC_W-1:0]  pc_next,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [TMR_W-1:0] wait_cnt;
  logic             lu;
  logic             mem_hold;
  logic             mem_timeout;

  pipe_seq_ctl_lu_detect #(
    .REG_W(REG_W)
  ) u_lu_detect (
    .ld_ex   (ld_ex),
    .ld_dest (ld_dest),
    .id_valid(id_valid),
    .id_src1 (id_src1),
    .id_src2 (id_src2),
    .lu      (lu)
  );

  assign mem_hold = mem_req && !mem_ack;

  // Stage controls are combinational so every hazard costs zero decision latency
  always_comb begin
    next_state  = state;
    pc_we       = 1'b0;
    pc_next     = pc + PC_W'(1);
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mem_timeout = 1'b0;
    if (rst) begin
      pc_next    = '0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      next_state = ST_RUN;
    end else if (state == ST_HALT) begin
      next_state = ST_HALT;
    end else if (state == ST_MEM_WAIT && !mem_ack) begin
      // An ack in the last counted cycle takes the branch below instead of timing out
      if (wait_cnt <= TMR_W'(1)) begin
        mem_timeout = 1'b1;
        next_state  = ST_HALT;
      end
    end else if (state != ST_MEM_WAIT && mem_hold) begin
      next_state = ST_MEM_WAIT;
    end else if (halt_req) begin
      exmem_we   = 1'b1;
      idex_flush = 1'b1;
      next_state = ST_HALT;
    end else if (br_taken) begin
      pc_we      = 1'b1;
      pc_next    = br_target;
      ifid_we    = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      next_state = ST_RUN;
    end else if (lu && state != ST_LU_STALL) begin
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      idex_flush = 1'b1;
      next_state = ST_LU_STALL;
    end else begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      next_state = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= next_state;
      halted <= (next_state == ST_HALT);
      if (mem_timeout) begin
        mem_err <= 1'b1;
      end
      if (state != ST_MEM_WAIT && next_state == ST_MEM_WAIT) begin
        wait_cnt <= TMR_W'(MEM_TIMEOUT);
      end else if (state == ST_MEM_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - TMR_W'(1);
      end
      if (!pc_we && state != ST_HALT && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctl.sv
// tb/tb_pipe_seq_ctl.sv - scoreboard bench for the pipeline sequencing controller
module tb_pipe_seq_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc = '0, br_target = '0;
  logic        ld_ex = 1'b0, id_valid = 1'b0, br_taken = 1'b0;
  logic        mem_req = 1'b0, mem_ack = 1'b0, halt_req = 1'b0;
  logic [3:0]  ld_dest = '0, id_src1 = '0, id_src2 = '0;
  logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, halted, mem_err;
  logic [7:0]  pc_next;
  logic [15:0] stall_cnt;

  pipe_seq_ctl dut (
    .clk(clk), .rst(rst), .pc(pc), .ld_ex(ld_ex), .ld_dest(ld_dest), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .br_taken(br_taken), .br_target(br_target),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .pc_we(pc_we),
    .pc_next(pc_next), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_we;
    logic [7:0]  pc_next;
    logic        ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, halted, mem_err;
    logic [15:0] stall_cnt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
    bit    chk_pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   sc = 0;

  function automatic obs_t mk(logic pw, logic [7:0] pn, logic iw, logic dw, logic xw,
                              logic ifl, logic dfl, logic h, logic me, logic [15:0] s);
    obs_t r;
    r.pc_we = pw; r.pc_next = pn; r.ifid_we = iw; r.idex_we = dw; r.exmem_we = xw;
    r.ifid_flush = ifl; r.idex_flush = dfl; r.halted = h; r.mem_err = me; r.stall_cnt = s;
    return r;
  endfunction

  function automatic obs_t adv(logic [7:0] pn, int s);  return mk(1, pn, 1, 1, 1, 0, 0, 0, 0, 16'(s)); endfunction
  function automatic obs_t frz(int s);                  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'(s)); endfunction
  function automatic obs_t lus(int s);                  return mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 16'(s)); endfunction
  function automatic obs_t brf(logic [7:0] t, int s);   return mk(1, t, 1, 1, 1, 1, 1, 0, 0, 16'(s)); endfunction
  function automatic obs_t hreq(int s);                 return mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 16'(s)); endfunction
  function automatic obs_t hlt(int s, logic me);        return mk(0, 0, 0, 0, 0, 0, 0, 1, me, 16'(s)); endfunction
  function automatic obs_t rstv();                      return mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 16'd0); endfunction

  function automatic obs_t cur_obs();
    return mk(pc_we, pc_next, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
              halted, mem_err, stall_cnt);
  endfunction

  task automatic push(string nm, obs_t v, bit chk_pc);
    exp_t e;
    e.name = nm; e.v = v; e.chk_pc = chk_pc;
    sb.push_back(e);
  endtask

  task automatic set_in(logic [7:0] p, logic ldx, logic [3:0] ldd, logic idv, logic [3:0] s1,
                        logic [3:0] s2, logic br, logic [7:0] tgt, logic mr, logic ma, logic hr);
    pc = p; ld_ex = ldx; ld_dest = ldd; id_valid = idv; id_src1 = s1; id_src2 = s2;
    br_taken = br; br_target = tgt; mem_req = mr; mem_ack = ma; halt_req = hr;
  endtask

  task automatic test_reset();
    obs_t o; exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        set_in(8'h33, 1, 4'd2, 1, 4'd2, 4'd0, 1, 8'h90, 1, 0, 0);
        push("reset_values", rstv(), 1'b1);
      end else begin
        rst = 1'b0;
        set_in(8'h05, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("first_run_cycle", adv(8'h06, sc), 1'b1);
      end
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_advance_wrap();
    logic [7:0] pcs [5] = '{8'h00, 8'h20, 8'h7F, 8'hFE, 8'hFF};
    obs_t o; exp_t e;
    foreach (pcs[i]) begin
      @(negedge clk);
      set_in(pcs[i], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push(pcs[i] == 8'hFF ? "pc_wrap" : "normal_advance", adv(8'(pcs[i] + 1), sc), 1'b1);
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_reg0();
    obs_t o; exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (i)
        0: set_in(8'h21, 1, 4'd0, 1, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        1: set_in(8'h22, 1, 4'd5, 0, 4'd5, 4'd0, 0, 0, 0, 0, 0);
        2: set_in(8'h23, 0, 4'd5, 1, 4'd5, 4'd5, 0, 0, 0, 0, 0);
        default: set_in(8'h24, 1, 4'd5, 1, 4'd7, 4'd6, 0, 0, 0, 0, 0);
      endcase
      push("no_hazard", adv(8'(8'h22 + i), sc), 1'b1);
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, o, e.v); end
    end
  endtask

  task automatic test_load_use();
    obs_t o; exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) set_in(8'h10, 1, 4'd3, 1, 4'd9, 4'd3, 0, 0, 0, 0, 0);
      else       set_in(8'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i == 0)      push("load_use_bubble", lus(sc), 1'b0);
      else if (i == 1) push("load_use_resume", adv(8'h11, sc), 1'b1);
      else             push("after_load_use", adv(8'h12, sc), 1'b1);
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
      if (i == 0) sc++;
    end
  endtask

  task automatic test_branch_hazard();
    obs_t o; exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (i)
        0: begin set_in(8'h30, 1, 4'd4, 1, 4'd4, 4'd1, 1, 8'h40, 0, 0, 0); push("branch_over_hazard", brf(8'h40, sc), 1'b1); end
        1: begin set_in(8'h40, 1, 4'd4, 1, 4'd4, 4'd1, 0, 0, 0, 0, 0);    push("hazard_after_branch", lus(sc), 1'b0); end
        2: begin set_in(8'h40, 1, 4'd4, 1, 4'd4, 4'd1, 1, 8'h50, 0, 0, 0); push("branch_in_lu_stall", brf(8'h50, sc), 1'b1); end
        default: begin set_in(8'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);       push("after_branch", adv(8'h51, sc), 1'b1); end
      endcase
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
      if (i == 1) sc++;
    end
  endtask

  // ack_at: cycle index carrying mem_ack; frozen cycles = ack_at
  task automatic test_mem_wait(int ack_at);
    obs_t o; exp_t e;
    for (int i = 0; i <= ack_at + 1; i++) begin
      @(negedge clk);
      set_in(8'h60, 0, 0, 0, 0, 0, 0, 0, (i <= ack_at), (i == ack_at), 0);
      if (i < ack_at) push("mem_wait_frozen", frz(sc), 1'b0);
      else            push(i == ack_at ? "mem_ack_advance" : "after_mem_wait", adv(8'h61, sc), 1'b1);
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, o, e.v); end
      if (i < ack_at) sc++;
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o; exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        #1 rst = 1'b1;
        push("async_reset_mid_wait", rstv(), 1'b1);
        #1;
      end else begin
        @(negedge clk);
        if (i < 3) begin
          set_in(8'h80, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
          push("pre_reset_frozen", frz(sc), 1'b0);
        end else begin
          rst = 1'b0;
          sc = 0;
          set_in(8'h81, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
          push("resume_after_reset", adv(8'h82, sc), 1'b1);
        end
        #2;
      end
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
      if (i < 3) sc++;
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i < 16) begin
        set_in(8'h90, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        push("timeout_frozen", frz(sc), 1'b0);
      end else if (i < 19) begin
        set_in(8'h90, 1, 4'd2, 1, 4'd2, 0, 1, 8'h10, 0, 0, 0);
        push("timeout_halted", hlt(sc, 1'b1), 1'b0);
      end else begin
        rst = 1'b1;
        set_in(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("reset_from_timeout", rstv(), 1'b1);
      end
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, o, e.v); end
      if (i < 16) sc++;
    end
    @(negedge clk);
    rst = 1'b0;
    sc = 0;
  endtask

  task automatic test_halt();
    obs_t o; exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) begin
        set_in(8'h70, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("halt_request", hreq(sc), 1'b0);
      end else if (i < 3) begin
        set_in(8'h71, 0, 0, 0, 0, 0, 1, 8'h20, 1, 0, 0);
        push("halt_state", hlt(sc, 1'b0), 1'b0);
      end else begin
        rst = 1'b1;
        push("reset_from_halt", rstv(), 1'b1);
      end
      #2;
      o = cur_obs(); e = sb.pop_front();
      if (!e.chk_pc) o.pc_next = e.v.pc_next;
      n_checks++;
      if (o !== e.v) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, o, e.v); end
      if (i == 0) sc++;
    end
    @(negedge clk);
    rst = 1'b0;
    sc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_advance_wrap();
    test_reg0();
    test_load_use();
    test_branch_hazard();
    test_mem_wait(4);
    test_mem_wait(15);
    test_reset_mid_wait();
    test_timeout();
    @(negedge clk);
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
